// File: rtl/dtc_rdo_sched_if.sv
// Word stream from the DTC readout scheduler to the DDL formatter.
// rdo_we strobes one word per cycle with no ready; ddl_xoff is a stop request,
// and at most one word that was already in flight follows its assertion.
interface dtc_rdo_sched_if #(
  parameter int DataW = 33
);
  logic [DataW-1:0] rdo_data;
  logic             rdo_we;
  logic [5:0]       rdo_ch;
  logic             rdo_sof;
  logic             rdo_eof;
  logic             ddl_xoff;

  modport master (
    output rdo_data, rdo_we, rdo_ch, rdo_sof, rdo_eof,
    input  ddl_xoff
  );

  modport slave (
    input  rdo_data, rdo_we, rdo_ch, rdo_sof, rdo_eof,
    output ddl_xoff
  );
endinterface

// File: rtl/dtc_rdo_sched.sv
// Reads one event out of NumDtc DTC RAMs channel by channel (header, then N words)
// and forwards the words to the DDL formatter, then confirms the event.
module dtc_rdo_sched #(
  parameter int NumDtc = 40,
  parameter int AddrW  = 10,
  parameter int DataW  = 33
) (
  input  logic                    DtcRamclkb,
  input  logic                    reset_n,
  input  logic                    DtcRamFlag,
  input  logic [NumDtc-1:0]       dtc_mask,
  output logic [NumDtc-1:0]       DtcRamenb,
  output logic [AddrW-1:0]        DtcRamaddrb,
  input  logic [NumDtc*DataW-1:0] DtcRamdoutb,
  output logic                    DtcRamReadConfirm,
  output logic                    busy,
  output logic [2:0]              dbg_state,
  dtc_rdo_sched_if.master         rdo
);

  localparam int ChW = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    HDR     = 3'd2,
    HDRW    = 3'd3,
    DATA    = 3'd4,
    DRAIN   = 3'd5,
    CONFIRM = 3'd6,
    WAITCLR = 3'd7
  } state_t;

  state_t            state;
  logic [ChW:0]      ptr;
  logic [ChW-1:0]    ch;
  logic [NumDtc-1:0] mask_q;
  logic              last_q;
  logic              sof_pend;
  logic [AddrW-1:0]  n_words;
  logic [AddrW-1:0]  addr_cnt;
  logic              confirm_q;

  // Tags of the read issued last cycle; its data is on DtcRamdoutb now.
  logic              rd_pend;
  logic              rd_sof;
  logic              rd_eof;
  logic              rd_hdr;
  logic [ChW-1:0]    rd_ch;

  logic              issue;
  logic [DataW-1:0]  rd_word;
  logic [AddrW-1:0]  hdr_n;
  logic              scan_found;
  logic [ChW-1:0]    scan_idx;
  logic [ChW-1:0]    last_idx;

  // Reads are issued combinationally so xoff stops the very next address.
  assign issue       = !rdo.ddl_xoff && (state == HDR || state == DATA);
  assign DtcRamenb   = issue ? ({{(NumDtc-1){1'b0}}, 1'b1} << ch) : '0;
  assign DtcRamaddrb = (state == DATA) ? addr_cnt : '0;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NumDtc; k++) begin
      if (rd_ch == ChW'(k)) rd_word = DtcRamdoutb[k*DataW +: DataW];
    end
  end

  assign hdr_n = rd_word[AddrW-1:0];

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    last_idx   = '0;
    for (int i = NumDtc - 1; i >= 0; i--) begin
      if (!mask_q[i] && (ChW+1)'(i) >= ptr) begin
        scan_found = 1'b1;
        scan_idx   = ChW'(i);
      end
    end
    for (int i = 0; i < NumDtc; i++) begin
      if (!mask_q[i]) last_idx = ChW'(i);
    end
  end

  assign rdo.rdo_data       = rd_pend ? rd_word : '0;
  assign rdo.rdo_we         = rd_pend;
  assign rdo.rdo_ch         = rd_ch;
  assign rdo.rdo_sof        = rd_sof;
  // A header only closes the event when it announces zero data words.
  assign rdo.rdo_eof        = rd_eof && (!rd_hdr || hdr_n == '0);
  assign DtcRamReadConfirm  = confirm_q;
  assign busy               = (state != IDLE);
  assign dbg_state          = state;

  always_ff @(posedge DtcRamclkb or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      ch        <= '0;
      mask_q    <= '0;
      last_q    <= 1'b0;
      sof_pend  <= 1'b0;
      n_words   <= '0;
      addr_cnt  <= '0;
      confirm_q <= 1'b0;
      rd_pend   <= 1'b0;
      rd_sof    <= 1'b0;
      rd_eof    <= 1'b0;
      rd_hdr    <= 1'b0;
      rd_ch     <= '0;
    end else begin
      confirm_q <= 1'b0;
      rd_pend   <= issue;
      if (issue) begin
        rd_ch  <= ch;
        rd_hdr <= (state == HDR);
        rd_sof <= (state == HDR) && sof_pend;
        rd_eof <= last_q && (state == HDR || addr_cnt == n_words);
      end else begin
        rd_hdr <= 1'b0;
        rd_sof <= 1'b0;
        rd_eof <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (DtcRamFlag) begin
            ptr      <= '0;
            mask_q   <= dtc_mask;
            sof_pend <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (scan_found) begin
            ch     <= scan_idx;
            last_q <= (scan_idx == last_idx);
            state  <= HDR;
          end else begin
            confirm_q <= 1'b1;
            state     <= CONFIRM;
          end
        end
        HDR: begin
          if (issue) begin
            sof_pend <= 1'b0;
            state    <= HDRW;
          end
        end
        HDRW: begin
          n_words  <= hdr_n;
          addr_cnt <= AddrW'(1);
          state    <= (hdr_n != '0) ? DATA : DRAIN;
        end
        DATA: begin
          // Stop on the last address instead of wrapping the counter.
          if (issue) begin
            if (addr_cnt == n_words) state <= DRAIN;
            else addr_cnt <= addr_cnt + AddrW'(1);
          end
        end
        DRAIN: begin
          if (!rd_pend) begin
            ptr   <= {1'b0, ch} + (ChW+1)'(1);
            state <= SCAN;
          end
        end
        CONFIRM: state <= WAITCLR;
        WAITCLR: begin
          if (!DtcRamFlag) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_rdo_sched.sv
// Directed bench for dtc_rdo_sched: RAM model, expected word queue, event-level checks.
module tb_dtc_rdo_sched;

  localparam int NUM_DTC = 40;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 33;
  localparam int W       = 41;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     flag;
  logic [NUM_DTC-1:0]       dtc_mask;
  logic [NUM_DTC-1:0]       enb;
  logic [ADDR_W-1:0]        addr;
  logic [NUM_DTC*DATA_W-1:0] dout = '0;
  logic                     confirm;
  logic                     busy;
  logic [2:0]               dbg_state;

  dtc_rdo_sched_if #(.DataW(DATA_W)) rdo_bus ();

  dtc_rdo_sched #(.NumDtc(NUM_DTC), .AddrW(ADDR_W), .DataW(DATA_W)) dut (
    .DtcRamclkb        (clk),
    .reset_n           (reset_n),
    .DtcRamFlag        (flag),
    .dtc_mask          (dtc_mask),
    .DtcRamenb         (enb),
    .DtcRamaddrb       (addr),
    .DtcRamdoutb       (dout),
    .DtcRamReadConfirm (confirm),
    .busy              (busy),
    .dbg_state         (dbg_state),
    .rdo               (rdo_bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  int hdr_n [NUM_DTC];

  function automatic logic [DATA_W-1:0] ram_word(input int c, input int a);
    if (a == 0) return DATA_W'(hdr_n[c]) | (DATA_W'(c) << 16);
    return (DATA_W'(1) << 32) | (DATA_W'(c) << 16) | DATA_W'(a);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NUM_DTC; k++) begin
      if (enb[k]) dout[k*DATA_W +: DATA_W] <= ram_word(k, int'(addr));
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;
  int n_confirm = 0;
  int onehot_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int build_exp(input logic [NUM_DTC-1:0] m);
    int last = -1;
    int cnt = 0;
    logic first = 1'b1;
    for (int c = 0; c < NUM_DTC; c++) if (!m[c]) last = c;
    for (int c = 0; c < NUM_DTC; c++) begin
      if (!m[c]) begin
        for (int a = 0; a <= hdr_n[c]; a++) begin
          exp_q.push_back({(a == 0) && first, (c == last) && (a == hdr_n[c]), 6'(c), ram_word(c, a)});
          cnt++;
        end
        first = 1'b0;
      end
    end
    return cnt;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n) begin
      if (rdo_bus.rdo_we) begin
        n_words++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("word", {rdo_bus.rdo_sof, rdo_bus.rdo_eof, rdo_bus.rdo_ch, rdo_bus.rdo_data}, e);
      end
      if (confirm) n_confirm++;
      if ($countones(enb) > 1) onehot_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_all_n(input int n);
    for (int c = 0; c < NUM_DTC; c++) hdr_n[c] = n;
  endtask

  task automatic run_event(input string tag, input int budget, input int exp_words);
    int c0;
    int w0;
    bit done;
    c0 = n_confirm;
    w0 = n_words;
    onehot_err = 0;
    done = 1'b0;
    flag = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (n_confirm != c0) done = 1'b1;
    end
    check({tag, "_confirm_seen"}, 64'(done), 64'd1);
    repeat (20) @(negedge clk);
    check({tag, "_confirm_once"}, 64'(n_confirm - c0), 64'd1);
    check({tag, "_words"}, 64'(n_words - w0), 64'(exp_words));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_onehot"}, 64'(onehot_err), 64'd0);
    check({tag, "_waitclr"}, 64'(dbg_state), 64'd7);
    flag = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, 64'(dbg_state), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_word(input string tag, input int c, input int a, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (rdo_bus.rdo_we && rdo_bus.rdo_ch == 6'(c) && rdo_bus.rdo_data[32] &&
          rdo_bus.rdo_data[ADDR_W-1:0] == ADDR_W'(a)) found = 1'b1;
    end
    check({tag, "_word_seen"}, 64'(found), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ne;
    int cnt;
    int enb_hits;
    int c0;
    reset_n = 1'b0;
    flag = 1'b0;
    dtc_mask = '0;
    rdo_bus.ddl_xoff = 1'b0;
    set_all_n(2);
    #1;
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_confirm", 64'(confirm), 64'd0);
    check("rst_we", 64'(rdo_bus.rdo_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // All channels, two data words each.
    set_all_n(2);
    dtc_mask = '0;
    ne = build_exp(dtc_mask);
    run_event("full", 2000, ne);

    // Only ch5 and ch30 live, header-only; a mid-event mask change is ignored.
    set_all_n(0);
    dtc_mask = '1;
    dtc_mask[5] = 1'b0;
    dtc_mask[30] = 1'b0;
    ne = build_exp(dtc_mask);
    fork
      run_event("sparse", 500, ne);
      begin
        repeat (4) @(negedge clk);
        dtc_mask = '0;
      end
    join

    // Backpressure in the middle of a long channel.
    set_all_n(2);
    hdr_n[3] = 20;
    dtc_mask = '0;
    ne = build_exp(dtc_mask);
    fork
      run_event("xoff", 3000, ne);
      begin
        wait_word("xoff", 3, 5, 500);
        rdo_bus.ddl_xoff = 1'b1;
        cnt = 0;
        enb_hits = 0;
        repeat (10) begin
          @(negedge clk);
          if (rdo_bus.rdo_we) cnt++;
          if (enb != '0) enb_hits++;
        end
        rdo_bus.ddl_xoff = 1'b0;
        check("xoff_slack", 64'(cnt <= 1), 64'd1);
        check("xoff_enb_low", 64'(enb_hits), 64'd0);
      end
    join

    // Everything masked; a held flag must not retrigger, a fresh rise must.
    dtc_mask = '1;
    run_event("allmask1", 200, 0);
    run_event("allmask2", 200, 0);

    // Maximum header count on ch0 reads through the last address.
    set_all_n(2);
    hdr_n[0] = 1023;
    dtc_mask = '1;
    dtc_mask[0] = 1'b0;
    ne = build_exp(dtc_mask);
    run_event("maxn", 3000, ne);

    // Reset in the middle of ch12 data, then restart from ch0.
    set_all_n(2);
    hdr_n[12] = 8;
    dtc_mask = '0;
    ne = build_exp(dtc_mask);
    c0 = n_confirm;
    flag = 1'b1;
    wait_word("rst_mid", 12, 3, 1000);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_enb", 64'(enb), 64'd0);
    check("rst_mid_addr", 64'(addr), 64'd0);
    check("rst_mid_we", 64'(rdo_bus.rdo_we), 64'd0);
    check("rst_mid_data", 64'(rdo_bus.rdo_data), 64'd0);
    check("rst_mid_ch", 64'(rdo_bus.rdo_ch), 64'd0);
    check("rst_mid_sof", 64'(rdo_bus.rdo_sof), 64'd0);
    check("rst_mid_eof", 64'(rdo_bus.rdo_eof), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_confirm", 64'(confirm), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_confirm", 64'(n_confirm - c0), 64'd0);
    exp_q.delete();
    ne = build_exp(dtc_mask);
    reset_n = 1'b1;
    run_event("rst_restart", 2000, ne);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtc_rdo_sched.md
DTC_RDO_SCHED -- requirements
Module: dtc_rdo_sched

Interface
REQ-001 Parameter NumDtc, default 40, is the number of DTC RAM channels.
REQ-002 Parameter AddrW, default 10, is the DTC RAM port-b address width.
REQ-003 Parameter DataW, default 33, is the DTC RAM word width per channel.
REQ-004 Port DtcRamclkb  in  1  is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset_n  in  1  is the reset: asynchronous, active-low.
REQ-006 Port DtcRamFlag  in  1  is high when every unmasked channel holds a complete event.
REQ-007 Port dtc_mask  in  NumDtc  has one bit per channel; 1 = channel excluded from readout.
REQ-008 Port ddl_xoff  in  1  is downstream backpressure; 1 = stop issuing reads.
REQ-009 Port DtcRamenb  out  NumDtc  is the one-hot RAM port-b enable.
REQ-010 Port DtcRamaddrb  out  AddrW  is the shared RAM port-b address.
REQ-011 Port DtcRamdoutb  in  NumDtc*DataW  is the concatenated RAM read data; channel k occupies bits [(k+1)*DataW-1 : k*DataW].
REQ-012 Port DtcRamReadConfirm  out  1  is a one-cycle pulse: all channels read, RAMs may be released.
REQ-013 Ports rdo_data out DataW, rdo_we out 1, rdo_ch out 6, rdo_sof out 1 and rdo_eof out 1 form the word stream to the DDL formatter: data, strobe, source channel, first word of event, last word of event.
REQ-014 Port busy  out  1  is high in every state except IDLE.

Function
REQ-015 The RAM read latency SHALL be one cycle: data for the address issued in cycle t is sampled in cycle t+1.
REQ-016 The FSM SHALL have the states IDLE, SCAN, HDR, HDRW, DATA, DRAIN, CONFIRM and WAITCLR.
REQ-017 IDLE -> SCAN when DtcRamFlag=1; the channel pointer SHALL load 0.
REQ-018 SCAN SHALL find the lowest unmasked channel index >= pointer and go to HDR, or go to CONFIRM if none exists; SCAN SHALL take 1 cycle regardless of pointer value.
REQ-019 HDR SHALL, when ddl_xoff=0, assert DtcRamenb[ch] with address 0 and go to HDRW; while ddl_xoff=1 it SHALL hold with enable low.
REQ-020 HDRW SHALL capture N = header word bits [AddrW-1:0], emit the header (rdo_we=1, rdo_sof=1 if it is the first emitted channel of the event), and go to DATA if N>0, else to DRAIN.
REQ-021 DATA SHALL issue addresses 1..N, one per cycle while ddl_xoff=0; it SHALL pause with enable low while ddl_xoff=1 and resume at the next unissued address.
REQ-022 Each read issued SHALL produce exactly one rdo_we pulse one cycle later, with rdo_ch = channel index; in-flight words SHALL still be emitted during xoff, so at most 1 word follows an xoff assertion.
REQ-023 DRAIN SHALL wait for the last in-flight word, set pointer = ch+1, and go to SCAN.
REQ-024 rdo_eof SHALL be asserted with the final word of the last unmasked channel; a header-only (N=0) last channel gets sof/eof on the header as applicable.
REQ-025 CONFIRM SHALL pulse DtcRamReadConfirm for exactly 1 cycle, then go to WAITCLR.
REQ-026 WAITCLR -> IDLE when DtcRamFlag=0, preventing a re-read of the same event.
REQ-027 If all channels are masked, the path IDLE->SCAN->CONFIRM SHALL emit no words and still pulse confirm.
REQ-028 dtc_mask SHALL be sampled once in IDLE at event start; mask changes mid-event SHALL be ignored.
REQ-029 The address counter SHALL be AddrW bits; N=2^AddrW-1 SHALL read the final address without wrap.
REQ-030 Exactly one bit of DtcRamenb SHALL be high in any cycle, or none.

Reset
REQ-031 When reset_n=0, the FSM SHALL go to IDLE and DtcRamenb=0, DtcRamaddrb=0, DtcRamReadConfirm=0, rdo_we=0, rdo_sof=0, rdo_eof=0, rdo_data=0, rdo_ch=0, busy=0, all immediately and asynchronously.
REQ-032 A reset mid-event SHALL abandon the event without a confirm pulse; after release, a still-high DtcRamFlag SHALL restart readout from channel 0.

Verification
REQ-033 Masks all 0, every header N=2, no xoff -> 120 words, channels 0..39 in order, sof on ch0 header, eof on ch39 word 2, single confirm pulse.
REQ-034 Mask = all ones except ch5 and ch30, N=0 for both -> 2 header words; sof on ch5, eof on ch30; confirm.
REQ-035 ddl_xoff held high for 10 cycles in mid-DATA -> at most 1 word after the rising edge, no address skipped or repeated, totals unchanged.
REQ-036 All masked, DtcRamFlag=1 -> zero rdo_we, one confirm; DtcRamFlag held high -> no second confirm until the flag drops and rises again.
REQ-037 ch0 N=1023 -> addresses 0..1023 each read once, no wrap to 0.
REQ-038 reset_n pulsed low during ch12 DATA -> outputs zero asynchronously, no confirm; flag still high -> readout restarts at ch0 header.
